can_tx_scheduler: RTL and testbench

Transmit-side scheduler sitting between the TX FIFO / high-priority buffer (HPB) and the CAN bit-stream engine. It picks the next message (HPB has priority over FIFO), registers it onto the engine's message bus, and runs the request/acknowledge handshake. It tracks completion, arbitration loss and transmit error, and pops the source buffer only once the message's fate is final. Error retries are bounded by a retry counter.

---
 rtl/can_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: picks HPB over FIFO, drives the engine request/ack
// handshake and pops the source once the message's fate is final.
// Optional bounded error retries: define CAN_TX_RETRY_LIMIT_EN.
module can_tx_scheduler #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_RETRY = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] txfifo_op,
  input  logic              TXBFLL,
  input  logic [DATA_W-1:0] txhpb_op,
  input  logic              tx_ack,
  input  logic              tx_done,
  input  logic              arb_lost,
  input  logic              tx_err,
  output logic [DATA_W-1:0] tx_message,
  output logic              tx_req,
  output logic              tx_src,
  output logic              fifo_rd_en,
  output logic              hpb_clr,
  output logic              tx_ok,
  output logic              tx_abort,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  retry_cnt
);

  localparam int unsigned       CNT_CAP = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // The retry counter must be able to reach the retry limit.
  if (MAX_RETRY > CNT_CAP) begin : g_bad_cnt_w
    $error("CNT_W too narrow to hold MAX_RETRY");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_REQ    = 2'd2,
    S_ACTIVE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic [DATA_W-1:0]  msg_q, msg_d;
  logic               src_q, src_d;
  logic               req_q, req_d;
  logic               fifo_rd_q, fifo_rd_d;
  logic               hpb_clr_q, hpb_clr_d;
  logic               ok_q, ok_d;
  logic               abort_q, abort_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]   retry_inc;

  assign retry_inc = (retry_q == CNT_MAX) ? retry_q : retry_q + CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      msg_q     <= '0;
      src_q     <= 1'b0;
      req_q     <= 1'b0;
      fifo_rd_q <= 1'b0;
      hpb_clr_q <= 1'b0;
      ok_q      <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      msg_q     <= msg_d;
      src_q     <= src_d;
      req_q     <= req_d;
      fifo_rd_q <= fifo_rd_d;
      hpb_clr_q <= hpb_clr_d;
      ok_q      <= ok_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      retry_q   <= retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    msg_d     = msg_q;
    src_d     = src_q;
    req_d     = req_q;
    fifo_rd_d = 1'b0;
    hpb_clr_d = 1'b0;
    ok_d      = 1'b0;
    abort_d   = 1'b0;
    retry_d   = retry_q;

    unique case (state_q)
      S_IDLE: begin
        if (tx_enable && (TXBFLL || !fifo_empty)) begin
          sel_d   = TXBFLL;
          state_d = S_LOAD;
          // Retries are counted per message source; a switch starts afresh.
          if (TXBFLL != src_q) begin
            retry_d = '0;
          end
        end
      end
      S_LOAD: begin
        msg_d   = sel_q ? txhpb_op : txfifo_op;
        src_d   = sel_q;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req_q && tx_ack) begin
          req_d   = 1'b0;
          state_d = S_ACTIVE;
        end else begin
          req_d   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (tx_done) begin
          fifo_rd_d = ~src_q;
          hpb_clr_d = src_q;
          ok_d      = 1'b1;
          retry_d   = '0;
          state_d   = S_IDLE;
        end else if (tx_err) begin
          retry_d = retry_inc;
          state_d = S_IDLE;
`ifdef CAN_TX_RETRY_LIMIT_EN
          if (retry_inc == CNT_W'(MAX_RETRY)) begin
            fifo_rd_d = ~src_q;
            hpb_clr_d = src_q;
            abort_d   = 1'b1;
            retry_d   = '0;
          end
`endif
        end else if (arb_lost) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign tx_message = msg_q;
  assign tx_req     = req_q;
  assign tx_src     = src_q;
  assign fifo_rd_en = fifo_rd_q;
  assign hpb_clr    = hpb_clr_q;
  assign tx_ok      = ok_q;
  assign tx_abort   = abort_q;
  assign tx_busy    = busy_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed self-checking bench for can_tx_scheduler; expected values are
// hand-derived from the scheduler's timing (select edge N, message N+1, req N+2).
module tb_can_tx_scheduler;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] MSG_A  = 128'hA0A0_0001_1111_2222_3333_4444_5555_6666;
  localparam logic [DATA_W-1:0] MSG_H  = 128'hB1B1_0002_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [DATA_W-1:0] MSG_F  = 128'hC2C2_0003_DDDD_EEEE_FFFF_0000_1234_5678;
  localparam logic [DATA_W-1:0] MSG_F2 = 128'hD3D3_0004_0101_0202_0303_0404_0505_0606;
  localparam logic [DATA_W-1:0] MSG_H2 = 128'hE4E4_0005_1010_2020_3030_4040_5050_6060;
  localparam logic [DATA_W-1:0] MSG_F3 = 128'hF5F5_0006_ABCD_EF01_2345_6789_9876_5432;
  localparam logic [DATA_W-1:0] MSG_F4 = 128'h0606_0007_CAFE_BABE_DEAD_BEEF_0BAD_F00D;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              tx_enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] txfifo_op;
  logic              TXBFLL;
  logic [DATA_W-1:0] txhpb_op;
  logic              tx_ack;
  logic              tx_done;
  logic              arb_lost;
  logic              tx_err;
  logic [DATA_W-1:0] tx_message;
  logic              tx_req;
  logic              tx_src;
  logic              fifo_rd_en;
  logic              hpb_clr;
  logic              tx_ok;
  logic              tx_abort;
  logic              tx_busy;
  logic [CNT_W-1:0]  retry_cnt;

  logic [3:0] pulses;
  assign pulses = {fifo_rd_en, hpb_clr, tx_ok, tx_abort};

  int checks = 0;
  int errors = 0;

  can_tx_scheduler #(
    .DATA_W   (DATA_W),
    .MAX_RETRY(8),
    .CNT_W    (CNT_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_enable (tx_enable),
    .fifo_empty(fifo_empty),
    .txfifo_op (txfifo_op),
    .TXBFLL    (TXBFLL),
    .txhpb_op  (txhpb_op),
    .tx_ack    (tx_ack),
    .tx_done   (tx_done),
    .arb_lost  (arb_lost),
    .tx_err    (tx_err),
    .tx_message(tx_message),
    .tx_req    (tx_req),
    .tx_src    (tx_src),
    .fifo_rd_en(fifo_rd_en),
    .hpb_clr   (hpb_clr),
    .tx_ok     (tx_ok),
    .tx_abort  (tx_abort),
    .tx_busy   (tx_busy),
    .retry_cnt (retry_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // From IDLE with a selectable source: LOAD, REQ, req high, ack -> ACTIVE.
  task automatic to_active();
    tick();
    tick();
    tick();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n  = 1'b0;
    tx_enable  = 1'b0;
    fifo_empty = 1'b1;
    txfifo_op  = '0;
    TXBFLL     = 1'b0;
    txhpb_op   = '0;
    tx_ack     = 1'b0;
    tx_done    = 1'b0;
    arb_lost   = 1'b0;
    tx_err     = 1'b0;
    tick();
    tick();
    checks++;
    if ({tx_message, tx_req, tx_src, pulses, tx_busy, retry_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%0b src=%0b pulses=%b busy=%0b retry=%0d msg=%h exp all 0",
               tx_req, tx_src, pulses, tx_busy, retry_cnt, tx_message);
    end
    sys_rst_n = 1'b1;
    tick();
    // FIFO holds a message but the controller is not enabled.
    fifo_empty = 1'b0;
    txfifo_op  = MSG_A;
    tick();
    tick();
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_gate busy got %0b exp 0", tx_busy);
    end
  endtask

  task automatic test_fifo_only();
    tx_enable = 1'b1;
    tick();
    checks++;
    if ({tx_busy, tx_req} !== 2'b10) begin
      errors++;
      $display("FAIL fifo_load busy/req got %b exp 10", {tx_busy, tx_req});
    end
    tick();
    checks++;
    if ({tx_message, tx_src, tx_req} !== {MSG_A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fifo_msg got msg=%h src=%0b req=%0b exp msg=%h src=0 req=0",
               tx_message, tx_src, tx_req, MSG_A);
    end
    tick();
    checks++;
    if (tx_req !== 1'b1) begin
      errors++;
      $display("FAIL fifo_req_rise got %0b exp 1", tx_req);
    end
    tick();
    tick();
    checks++;
    if (tx_req !== 1'b1) begin
      errors++;
      $display("FAIL fifo_req_hold got %0b exp 1", tx_req);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    checks++;
    if ({tx_req, tx_busy} !== 2'b01) begin
      errors++;
      $display("FAIL fifo_ack req/busy got %b exp 01", {tx_req, tx_busy});
    end
    tick();
    tick();
    checks++;
    if ({pulses, tx_busy} !== 5'b0000_1) begin
      errors++;
      $display("FAIL fifo_active_wait pulses/busy got %b exp 00001", {pulses, tx_busy});
    end
    tx_done = 1'b1;
    tick();
    tx_done    = 1'b0;
    fifo_empty = 1'b1;
    checks++;
    if ({pulses, tx_busy} !== 5'b1010_0) begin
      errors++;
      $display("FAIL fifo_done pulses/busy got %b exp 10100", {pulses, tx_busy});
    end
    tick();
    checks++;
    if ({pulses, tx_busy} !== 5'b0000_0) begin
      errors++;
      $display("FAIL fifo_pulse_width pulses/busy got %b exp 00000", {pulses, tx_busy});
    end
  endtask

  task automatic test_back_to_back();
    TXBFLL     = 1'b1;
    txhpb_op   = MSG_H;
    fifo_empty = 1'b0;
    txfifo_op  = MSG_F;
    tick();
    tick();
    checks++;
    if ({tx_message, tx_src} !== {MSG_H, 1'b1}) begin
      errors++;
      $display("FAIL b2b_hpb_first got msg=%h src=%0b exp msg=%h src=1", tx_message, tx_src, MSG_H);
    end
    tick();
    tx_ack = 1'b1;
    tick();
    tx_ack  = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    TXBFLL  = 1'b0;
    checks++;
    if (pulses !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_hpb_done pulses got %b exp 0110", pulses);
    end
    tick();
    tick();
    checks++;
    if ({tx_message, tx_src, tx_req} !== {MSG_F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_fifo_msg got msg=%h src=%0b req=%0b exp msg=%h src=0 req=0",
               tx_message, tx_src, tx_req, MSG_F);
    end
    tick();
    checks++;
    if (tx_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap req 3 cycles after done got %0b exp 1", tx_req);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack  = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done    = 1'b0;
    fifo_empty = 1'b1;
    checks++;
    if (pulses !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_fifo_done pulses got %b exp 1010", pulses);
    end
  endtask

  task automatic test_arb_lost();
    fifo_empty = 1'b0;
    txfifo_op  = MSG_F2;
    to_active();
    arb_lost = 1'b1;
    TXBFLL   = 1'b1;
    txhpb_op = MSG_H2;
    tick();
    arb_lost = 1'b0;
    checks++;
    if ({pulses, tx_busy, retry_cnt} !== {4'b0000, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL arb_lost_nopop pulses=%b busy=%0b retry=%0d exp 0000 0 0", pulses, tx_busy, retry_cnt);
    end
    tick();
    tick();
    checks++;
    if ({tx_message, tx_src} !== {MSG_H2, 1'b1}) begin
      errors++;
      $display("FAIL arb_lost_reselect got msg=%h src=%0b exp msg=%h src=1", tx_message, tx_src, MSG_H2);
    end
    tick();
    tx_ack = 1'b1;
    tick();
    tx_ack  = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    TXBFLL  = 1'b0;
    checks++;
    if (pulses !== 4'b0110) begin
      errors++;
      $display("FAIL arb_lost_hpb_done pulses got %b exp 0110", pulses);
    end
  endtask

  task automatic test_done_err_same_cycle();
    to_active();
    tx_err = 1'b1;
    tick();
    tx_err = 1'b0;
    checks++;
    if ({pulses, tx_busy, retry_cnt} !== {4'b0000, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL err_single pulses=%b busy=%0b retry=%0d exp 0000 0 1", pulses, tx_busy, retry_cnt);
    end
    to_active();
    checks++;
    if ({tx_message, retry_cnt} !== {MSG_F2, 4'd1}) begin
      errors++;
      $display("FAIL err_reselect msg=%h retry=%0d exp msg=%h retry=1", tx_message, retry_cnt, MSG_F2);
    end
    tx_done = 1'b1;
    tx_err  = 1'b1;
    tick();
    tx_done    = 1'b0;
    tx_err     = 1'b0;
    fifo_empty = 1'b1;
    checks++;
    if ({pulses, retry_cnt} !== {4'b1010, 4'd0}) begin
      errors++;
      $display("FAIL done_over_err pulses=%b retry=%0d exp 1010 0", pulses, retry_cnt);
    end
  endtask

  task automatic test_retry_limit();
    fifo_empty = 1'b0;
    txfifo_op  = MSG_F3;
    for (int i = 1; i <= 8; i++) begin
      to_active();
      tx_err = 1'b1;
      tick();
      tx_err = 1'b0;
      if (i < 8) begin
        checks++;
        if ({pulses, retry_cnt} !== {4'b0000, 4'(i)}) begin
          errors++;
          $display("FAIL retry_step%0d pulses=%b retry=%0d exp 0000 %0d", i, pulses, retry_cnt, i);
        end
      end else begin
`ifdef CAN_TX_RETRY_LIMIT_EN
        fifo_empty = 1'b1;
        checks++;
        if ({pulses, retry_cnt} !== {4'b1001, 4'd0}) begin
          errors++;
          $display("FAIL retry_abort pulses=%b retry=%0d exp 1001 0", pulses, retry_cnt);
        end
        tick();
        tick();
        checks++;
        if ({tx_busy, pulses} !== 5'b0_0000) begin
          errors++;
          $display("FAIL retry_after_abort busy/pulses got %b exp 00000", {tx_busy, pulses});
        end
`else
        checks++;
        if ({pulses, retry_cnt} !== {4'b0000, 4'd8}) begin
          errors++;
          $display("FAIL retry_unlimited pulses=%b retry=%0d exp 0000 8", pulses, retry_cnt);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({tx_req, tx_message} !== {1'b1, MSG_F3}) begin
          errors++;
          $display("FAIL retry_ninth_req req=%0b msg=%h exp 1 %h", tx_req, tx_message, MSG_F3);
        end
        tx_ack = 1'b1;
        tick();
        tx_ack  = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done    = 1'b0;
        fifo_empty = 1'b1;
        checks++;
        if ({pulses, retry_cnt} !== {4'b1010, 4'd0}) begin
          errors++;
          $display("FAIL retry_final_done pulses=%b retry=%0d exp 1010 0", pulses, retry_cnt);
        end
`endif
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    fifo_empty = 1'b0;
    txfifo_op  = MSG_F4;
    to_active();
    tick();
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_message, tx_req, tx_src, pulses, tx_busy, retry_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs req=%0b src=%0b pulses=%b busy=%0b retry=%0d msg=%h exp all 0",
               tx_req, tx_src, pulses, tx_busy, retry_cnt, tx_message);
    end
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({tx_req, tx_message, tx_src} !== {1'b1, MSG_F4, 1'b0}) begin
      errors++;
      $display("FAIL midreset_rerequest req=%0b msg=%h src=%0b exp 1 %h 0", tx_req, tx_message, tx_src, MSG_F4);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack  = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done    = 1'b0;
    fifo_empty = 1'b1;
    checks++;
    if (pulses !== 4'b1010) begin
      errors++;
      $display("FAIL midreset_done pulses got %b exp 1010", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_only();
    test_back_to_back();
    test_arb_lost();
    test_done_err_same_cycle();
    test_retry_limit();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
